spi_lane_row_driver: RTL

//  Parametrised N-lane SPI transmitter for the LED matrix output stage. Accepts pixel words over valid/ready.

---
 rtl/spi_lane_row_driver_if.sv | 17 +
 rtl/spi_lane_row_driver.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_lane_row_driver_if.sv
// spi_lane_row_driver_if
//   Valid/ready pixel-word stream feeding spi_lane_row_driver.
//   s_valid  source -> sink   word on s_data is valid
//   s_ready  sink   -> source sink accepts a word this cycle
//   s_data   source -> sink   NUM_LANES words, lane i at [i*WORD_W +: WORD_W]
//   master = word source (frame buffer reader), slave = the driver.
interface spi_lane_row_driver_if #(
   parameter int unsigned NUM_LANES = 8,
   parameter int unsigned WORD_W    = 8
);
   logic                        s_valid;
   logic                        s_ready;
   logic [NUM_LANES*WORD_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/spi_lane_row_driver.sv
// spi_lane_row_driver
//   N-lane SPI transmitter for the LED matrix output stage. Each accepted word is shifted out
//   MSB-first on NUM_LANES MOSI lines sharing spi_clk (idle low, slaves sample on rising edge).
//   After WORDS_PER_ROW words the 74HC595-style row chain is advanced and latched.
// Configuration macro: SPI_LANE_ROW_DRIVER_ROWSEL_EN
//   defined   : ROW_SHIFT/LATCH sequencing drives shift_* and row_idx.
//   undefined : row chain is external; shift_* held 0, row_idx stays 0, row_done still pulses.
// Ports
//   clk, rst    system clock, synchronous active-high reset
//   s_if        slave side of the pixel word stream (s_valid/s_ready/s_data)
//   spi_clk     SPI clock          spi_mosi   one serial bit per lane
//   shift_clk   row chain shift    shift_ser  row chain data (walking one)
//   shift_stcp  row chain latch    shift_en   row chain output enable, active-low
//   row_idx     current row        row_done   1-cycle pulse per completed row
//   busy        high outside IDLE
module spi_lane_row_driver #(
   parameter int unsigned NUM_LANES     = 8,
   parameter int unsigned WORD_W        = 8,
   parameter int unsigned WORDS_PER_ROW = 48,
   parameter int unsigned NUM_ROWS      = 8,
   parameter int unsigned CLK_DIV       = 2,
   parameter int unsigned BLANK_CYCLES  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   spi_lane_row_driver_if.slave        s_if,
   output logic                        spi_clk,
   output logic [NUM_LANES-1:0]        spi_mosi,
   output logic                        shift_clk,
   output logic                        shift_ser,
   output logic                        shift_stcp,
   output logic                        shift_en,
   output logic [$clog2(NUM_ROWS)-1:0] row_idx,
   output logic                        row_done,
   output logic                        busy
);

   localparam int unsigned DataW = NUM_LANES * WORD_W;
   localparam int unsigned BitW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int unsigned WordW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
   localparam int unsigned RowW  = $clog2(NUM_ROWS);
   // LATCH stretches so that ROW_SHIFT + LATCH keeps the outputs blanked >= BLANK_CYCLES.
   localparam int unsigned LatchCycles = (BLANK_CYCLES > 2 * CLK_DIV) ?
                                         BLANK_CYCLES - 2 * CLK_DIV : 1;
   localparam int unsigned PhMax = (2 * CLK_DIV > LatchCycles) ? 2 * CLK_DIV : LatchCycles;
   localparam int unsigned PhW   = $clog2(PhMax);

`ifdef SPI_LANE_ROW_DRIVER_ROWSEL_EN
   localparam logic EnRst = 1'b1;
`else
   localparam logic EnRst = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StShift, StRowShift, StLatch} state_e;

   state_e               state_q, state_d;
   logic [PhW-1:0]       ph_q, ph_d, ph_inc;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [WordW-1:0]     word_q, word_d;
   logic [DataW-1:0]     sr_q, sr_d;
   logic [RowW-1:0]      row_q, row_d;
   logic                 spi_clk_q, spi_clk_d;
   logic                 ready_q, ready_d;
   logic                 sclk_q, sclk_d;
   logic                 ser_q, ser_d;
   logic                 stcp_q, stcp_d;
   logic                 en_q, en_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 accept, last_ph, last_bit, last_word;

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      bit_d     = bit_q;
      word_d    = word_q;
      sr_d      = sr_q;
      row_d     = row_q;
      spi_clk_d = spi_clk_q;
      ready_d   = 1'b0;
      sclk_d    = sclk_q;
      ser_d     = ser_q;
      stcp_d    = 1'b0;
      en_d      = en_q;
      done_d    = 1'b0;

      accept    = s_if.s_valid & ready_q;
      ph_inc    = ph_q + 1'b1;
      last_ph   = (ph_q == PhW'(2 * CLK_DIV - 1));
      last_bit  = (bit_q == BitW'(WORD_W - 1));
      last_word = (word_q == WordW'(WORDS_PER_ROW - 1));

      unique case (state_q)
         StIdle: begin
            ready_d = 1'b1;
            if (accept) begin
               state_d   = StShift;
               sr_d      = s_if.s_data;
               ph_d      = '0;
               bit_d     = '0;
               spi_clk_d = 1'b0;
               ready_d   = 1'b0;
            end
         end

         StShift: begin
            ph_d      = ph_inc;
            spi_clk_d = (ph_inc >= PhW'(CLK_DIV));
            // Ready is raised for the final high-phase cycle so the next word follows seamlessly.
            ready_d   = (ph_q == PhW'(2 * CLK_DIV - 2)) && last_bit && !last_word;
            if (last_ph) begin
               ph_d      = '0;
               spi_clk_d = 1'b0;
               if (!last_bit) begin
                  bit_d = bit_q + 1'b1;
                  for (int unsigned i = 0; i < NUM_LANES; i++) begin
                     sr_d[i*WORD_W +: WORD_W] = sr_q[i*WORD_W +: WORD_W] << 1;
                  end
               end else begin
                  bit_d = '0;
                  if (last_word) begin
                     word_d = '0;
`ifdef SPI_LANE_ROW_DRIVER_ROWSEL_EN
                     state_d = StRowShift;
                     sclk_d  = 1'b1;
                     // Inject the walking one when wrapping back to row 0.
                     ser_d   = (row_q == RowW'(NUM_ROWS - 1));
                     en_d    = 1'b1;
`else
                     state_d = StIdle;
                     done_d  = 1'b1;
                     ready_d = 1'b1;
`endif
                  end else begin
                     word_d = word_q + 1'b1;
                     if (accept) begin
                        sr_d = s_if.s_data;
                     end else begin
                        state_d = StIdle;
                        ready_d = 1'b1;
                     end
                  end
               end
            end
         end

         StRowShift: begin
            ph_d   = ph_inc;
            sclk_d = (ph_inc < PhW'(CLK_DIV));
            if (last_ph) begin
               state_d = StLatch;
               ph_d    = '0;
               sclk_d  = 1'b0;
               ser_d   = 1'b0;
               stcp_d  = 1'b1;
            end
         end

         StLatch: begin
            ph_d = ph_inc;
            if (ph_q == PhW'(LatchCycles - 1)) begin
               state_d = StIdle;
               ph_d    = '0;
               en_d    = 1'b0;
               row_d   = (row_q == RowW'(NUM_ROWS - 1)) ? '0 : row_q + 1'b1;
               done_d  = 1'b1;
               ready_d = 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ph_q      <= '0;
         bit_q     <= '0;
         word_q    <= '0;
         sr_q      <= '0;
         row_q     <= '0;
         spi_clk_q <= 1'b0;
         ready_q   <= 1'b0;
         sclk_q    <= 1'b0;
         ser_q     <= 1'b0;
         stcp_q    <= 1'b0;
         en_q      <= EnRst;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bit_q     <= bit_d;
         word_q    <= word_d;
         sr_q      <= sr_d;
         row_q     <= row_d;
         spi_clk_q <= spi_clk_d;
         ready_q   <= ready_d;
         sclk_q    <= sclk_d;
         ser_q     <= ser_d;
         stcp_q    <= stcp_d;
         en_q      <= en_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

   // MOSI is the MSB of each lane's shift register, so it only moves when the register shifts.
   always_comb begin
      spi_mosi = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         spi_mosi[i] = sr_q[i*WORD_W + WORD_W - 1];
      end
   end

   assign s_if.s_ready = ready_q;
   assign spi_clk      = spi_clk_q;
   assign shift_clk    = sclk_q;
   assign shift_ser    = ser_q;
   assign shift_stcp   = stcp_q;
   assign shift_en     = en_q;
   assign row_idx      = row_q;
   assign row_done     = done_q;
   assign busy         = busy_q;

endmodule
